// File: rtl/spi_instr_decoder.sv
// Turns two-byte SPI frames (setup byte, then data byte) into register-bank read/write strobes.
// Define SPI_DCD_ADDR_CHECK_EN to block accesses whose address is >= NUM_REGS.
module spi_instr_decoder #(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write
);

    typedef enum logic {
        S_SETUP,
        S_DATA
    } state_t;

`ifdef SPI_DCD_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    state_t state_reg;
    logic   rw_reg;
    logic   illegal_reg;
    logic   ill_rd_reg;
    logic   setup_illegal;
    logic   unused_bits;

    assign setup_illegal = ADDR_CHECK && (int'({1'b0, data_in[ADDR_W-1:0]}) >= NUM_REGS);

    // Bit 6 and any bits above the address field carry no meaning.
    assign unused_bits = ^data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_SETUP;
            rw_reg      <= 1'b0;
            illegal_reg <= 1'b0;
            ill_rd_reg  <= 1'b0;
            read        <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            data_write  <= 8'h00;
            data_out    <= 8'h00;
        end else begin
            read       <= 1'b0;
            write      <= 1'b0;
            ill_rd_reg <= 1'b0;

            // Read data is captured at the end of the strobe cycle, when the bank has settled.
            if (read) begin
                data_out <= data_read;
            end else if (ill_rd_reg) begin
                data_out <= 8'hFF;
            end

            if (byte_sync) begin
                case (state_reg)
                    S_SETUP: begin
                        state_reg   <= S_DATA;
                        rw_reg      <= data_in[7];
                        addr        <= data_in[ADDR_W-1:0];
                        illegal_reg <= setup_illegal;
                        if (!data_in[7]) begin
                            if (setup_illegal) begin
                                ill_rd_reg <= 1'b1;
                            end else begin
                                read <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        state_reg <= S_SETUP;
                        if (rw_reg && !illegal_reg) begin
                            data_write <= data_in;
                            write      <= 1'b1;
                        end
                    end
                    default: state_reg <= S_SETUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Directed bench for spi_instr_decoder: frames are driven on the falling edge, outputs checked on the next one.
module tb_spi_instr_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;

    logic [7:0] mem [0:63];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    assign data_read = mem[addr];

    spi_instr_decoder #(.ADDR_W(6), .NUM_REGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write)
    );

    always @(negedge clk) begin
        if (read)  rd_cnt++;
        if (write) wr_cnt++;
        if (read && write) begin
            errors++;
            $display("FAIL overlap read=%0b write=%0b required not both high", read, write);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One byte_sync pulse; returns on the falling edge of the cycle after the sampling edge (T+1).
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = b;
        @(negedge clk);
        byte_sync = 1'b0;
    endtask

    // Two pulses in consecutive cycles; returns at T+1 of the second byte.
    task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = b0;
        @(negedge clk);
        data_in   = b1;
        @(negedge clk);
        byte_sync = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[5]  = 8'hA7;
        mem[2]  = 8'h5A;
        mem[3]  = 8'hC3;
        mem[10] = 8'h99;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_read", {31'b0, read}, 32'h0);
        check("rst_write", {31'b0, write}, 32'h0);
        check("rst_addr", {26'b0, addr}, 32'h0);
        check("rst_data_write", {24'b0, data_write}, 32'h0);
        check("rst_data_out", {24'b0, data_out}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_rd_cnt", rd_cnt, 0);
        check("idle_wr_cnt", wr_cnt, 0);

        // Write frame 85 / 3C
        send_byte(8'h85);
        check("wr_setup_no_read", {31'b0, read}, 32'h0);
        check("wr_setup_no_write", {31'b0, write}, 32'h0);
        send_byte(8'h3C);
        check("wr_strobe", {31'b0, write}, 32'h1);
        check("wr_addr", {26'b0, addr}, 32'h05);
        check("wr_data", {24'b0, data_write}, 32'h3C);
        @(negedge clk);
        check("wr_strobe_end", {31'b0, write}, 32'h0);
        check("wr_cnt1", wr_cnt, 1);
        check("wr_rd_cnt0", rd_cnt, 0);
        check("wr_data_out_kept", {24'b0, data_out}, 32'h0);

        // Read frame 05 / dummy
        send_byte(8'h05);
        check("rd_strobe", {31'b0, read}, 32'h1);
        check("rd_addr", {26'b0, addr}, 32'h05);
        @(negedge clk);
        check("rd_strobe_end", {31'b0, read}, 32'h0);
        check("rd_data_out", {24'b0, data_out}, 32'hA7);
        send_byte(8'h00);
        check("rd_dummy_no_read", {31'b0, read}, 32'h0);
        check("rd_dummy_no_write", {31'b0, write}, 32'h0);
        @(negedge clk);
        check("rd_data_out_hold", {24'b0, data_out}, 32'hA7);
        check("rd_cnt1", rd_cnt, 1);

        // Back-to-back pulses: write 82/11 then read 02/00
        send_pair(8'h82, 8'h11);
        check("b2b_write", {31'b0, write}, 32'h1);
        check("b2b_wr_addr", {26'b0, addr}, 32'h02);
        check("b2b_wr_data", {24'b0, data_write}, 32'h11);
        check("b2b_data_out_unchanged", {24'b0, data_out}, 32'hA7);
        @(negedge clk);
        byte_sync = 1'b1;
        data_in   = 8'h02;
        @(negedge clk);
        data_in   = 8'h00;
        check("b2b_read", {31'b0, read}, 32'h1);
        check("b2b_rd_addr", {26'b0, addr}, 32'h02);
        @(negedge clk);
        byte_sync = 1'b0;
        check("b2b_rd_data_out", {24'b0, data_out}, 32'h5A);
        check("b2b_dummy_no_read", {31'b0, read}, 32'h0);
        check("b2b_dummy_no_write", {31'b0, write}, 32'h0);
        check("b2b_wr_cnt", wr_cnt, 2);
        check("b2b_rd_cnt", rd_cnt, 2);

        // Reset between setup 81 and its data byte
        send_byte(8'h81);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", {26'b0, addr}, 32'h0);
        check("mid_rst_data_out", {24'b0, data_out}, 32'h0);
        check("mid_rst_data_write", {24'b0, data_write}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h03);
        check("post_rst_read", {31'b0, read}, 32'h1);
        check("post_rst_no_write", {31'b0, write}, 32'h0);
        check("post_rst_addr", {26'b0, addr}, 32'h03);
        @(negedge clk);
        check("post_rst_data_out", {24'b0, data_out}, 32'hC3);
        send_byte(8'h00);
        check("post_rst_dummy_no_write", {31'b0, write}, 32'h0);
        check("post_rst_wr_cnt", wr_cnt, 2);

        // Reserved bit 6 ignored
        send_byte(8'h45);
        check("rsvd_read", {31'b0, read}, 32'h1);
        check("rsvd_addr", {26'b0, addr}, 32'h05);
        @(negedge clk);
        check("rsvd_data_out", {24'b0, data_out}, 32'hA7);
        send_byte(8'h00);

        // Address 10 with NUM_REGS=8
        send_byte(8'h0A);
`ifdef SPI_DCD_ADDR_CHECK_EN
        check("oor_no_read", {31'b0, read}, 32'h0);
        @(negedge clk);
        check("oor_data_out_ff", {24'b0, data_out}, 32'hFF);
        send_byte(8'h00);
        send_byte(8'h8A);
        send_byte(8'h55);
        check("oor_no_write", {31'b0, write}, 32'h0);
        @(negedge clk);
        check("oor_wr_cnt", wr_cnt, 2);
        send_byte(8'h03);
        check("oor_realign_read", {31'b0, read}, 32'h1);
        send_byte(8'h00);
`else
        check("oor_read", {31'b0, read}, 32'h1);
        check("oor_addr", {26'b0, addr}, 32'h0A);
        @(negedge clk);
        check("oor_data_out", {24'b0, data_out}, 32'h99);
        send_byte(8'h00);
        send_byte(8'h8A);
        send_byte(8'h55);
        check("oor_write", {31'b0, write}, 32'h1);
        check("oor_wr_data", {24'b0, data_write}, 32'h55);
        @(negedge clk);
        check("oor_wr_cnt", wr_cnt, 3);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
